// File: rtl/crossbar_scheduler.sv
// crossbar_scheduler: round-robin scheduler for the 3-port packet switch.
// Inspects the show-ahead head of each input FIFO, resolves output contention
// with one rotating pointer per output, then pops winners and drives the
// output mux selects and output-RAM write strobes.
// Sequence per word: ARB (decide) -> XFER (strobes) -> SETTLE (FIFO heads update).
// Optional feature: define STATS_EN to add forward/drop counters on readdata.
module crossbar_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty1,
  input  logic        fifo_empty2,
  input  logic        fifo_empty3,
  input  logic [31:0] fifo_out1,
  input  logic [31:0] fifo_out2,
  input  logic [31:0] fifo_out3,
  input  logic        out_full1,
  input  logic        out_full2,
  input  logic        out_full3,
  output logic        fifo_rd1,
  output logic        fifo_rd2,
  output logic        fifo_rd3,
  output logic [1:0]  mux_sel1,
  output logic [1:0]  mux_sel2,
  output logic [1:0]  mux_sel3,
  output logic        out_ram_wr1,
  output logic        out_ram_wr2,
  output logic        out_ram_wr3,
  input  logic [1:0]  stat_addr,
  output logic [31:0] readdata
);

  typedef enum logic [1:0] {ARB = 2'd0, XFER = 2'd1, SETTLE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      empty_v;
  logic [3:0]      full_ext;     // indexed by dest; entry 0 (drop) never blocks
  logic [2:0][1:0] dest_v;
  logic [2:0]      elig_v;
  logic [2:0]      drop_v;
  logic [2:0]      fwd_pop_v;    // input won some output this ARB
  logic [2:0][1:0] win_v;        // per output: winning input 1..3, 0 = none
  logic [2:0]      fifo_rd_q, fifo_rd_d;
  logic [2:0]      out_wr_q, out_wr_d;
  logic [2:0][1:0] mux_sel_q, mux_sel_d;
  logic [2:0][1:0] rr_ptr_q, rr_ptr_d;
  logic            unused_payload;

  assign empty_v  = {fifo_empty3, fifo_empty2, fifo_empty1};
  assign full_ext = {out_full3, out_full2, out_full1, 1'b0};
  assign dest_v   = {fifo_out3[31:30], fifo_out2[31:30], fifo_out1[31:30]};
  // Payload bits are routed by the datapath mux, not inspected here.
  assign unused_payload = ^{fifo_out1[29:0], fifo_out2[29:0], fifo_out3[29:0]};

  // Highest-priority requester starting at ptr, wrapping 3 -> 1.
  function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [2:0] req);
    case (ptr)
      2'd2:    pick = req[1] ? 2'd2 : req[2] ? 2'd3 : req[0] ? 2'd1 : 2'd0;
      2'd3:    pick = req[2] ? 2'd3 : req[0] ? 2'd1 : req[1] ? 2'd2 : 2'd0;
      default: pick = req[0] ? 2'd1 : req[1] ? 2'd2 : req[2] ? 2'd3 : 2'd0;
    endcase
  endfunction

  // Pointer moves just past the input that was served: (in mod 3) + 1.
  function automatic logic [1:0] ptr_next(input logic [1:0] granted);
    case (granted)
      2'd1:    ptr_next = 2'd2;
      2'd2:    ptr_next = 2'd3;
      default: ptr_next = 2'd1;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    assign elig_v[gi]    = !empty_v[gi] && !full_ext[dest_v[gi]];
    assign drop_v[gi]    = elig_v[gi] && (dest_v[gi] == 2'd0);
    assign fwd_pop_v[gi] = (win_v[0] == 2'(gi + 1)) || (win_v[1] == 2'(gi + 1)) ||
                           (win_v[2] == 2'(gi + 1));
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_out
    logic [2:0] req;
    for (genvar gj = 0; gj < 3; gj++) begin : g_req
      assign req[gj] = elig_v[gj] && (dest_v[gj] == 2'(gi + 1));
    end
    assign win_v[gi] = pick(rr_ptr_q[gi], req);
  end

  // Next state, registered strobes and pointer updates.
  always_comb begin
    state_d   = state_q;
    fifo_rd_d = '0;
    out_wr_d  = '0;
    mux_sel_d = '0;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ARB: begin
        if (|(drop_v | fwd_pop_v)) begin
          fifo_rd_d = drop_v | fwd_pop_v;
          for (int k = 0; k < 3; k++) begin
            mux_sel_d[k] = win_v[k];
            out_wr_d[k]  = (win_v[k] != 2'd0);
          end
          state_d = XFER;
        end
      end
      XFER: begin
        for (int k = 0; k < 3; k++) begin
          if (out_wr_q[k]) rr_ptr_d[k] = ptr_next(mux_sel_q[k]);
        end
        state_d = SETTLE;
      end
      SETTLE:  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // State, strobe and pointer registers; reset clears strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB;
      fifo_rd_q <= '0;
      out_wr_q  <= '0;
      mux_sel_q <= '0;
      rr_ptr_q  <= {2'd1, 2'd1, 2'd1};
    end else begin
      state_q   <= state_d;
      fifo_rd_q <= fifo_rd_d;
      out_wr_q  <= out_wr_d;
      mux_sel_q <= mux_sel_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign fifo_rd1    = fifo_rd_q[0];
  assign fifo_rd2    = fifo_rd_q[1];
  assign fifo_rd3    = fifo_rd_q[2];
  assign mux_sel1    = mux_sel_q[0];
  assign mux_sel2    = mux_sel_q[1];
  assign mux_sel3    = mux_sel_q[2];
  assign out_ram_wr1 = out_wr_q[0];
  assign out_ram_wr2 = out_wr_q[1];
  assign out_ram_wr3 = out_wr_q[2];

`ifdef STATS_EN
  logic [2:0]       drop_q, drop_d;
  logic [3:0][31:0] cnt_q, cnt_d;   // [0..2] = fwd1..3, [3] = drop_cnt
  logic [1:0]       drop_num;

  assign drop_num = {1'b0, drop_q[0]} + {1'b0, drop_q[1]} + {1'b0, drop_q[2]};

  // Remember which pops were drops so XFER can count them; counters wrap.
  always_comb begin
    drop_d = (state_q == ARB) ? drop_v : 3'b000;
    cnt_d  = cnt_q;
    if (state_q == XFER) begin
      for (int k = 0; k < 3; k++) begin
        cnt_d[k] = cnt_q[k] + {31'd0, out_wr_q[k]};
      end
      cnt_d[3] = cnt_q[3] + {30'd0, drop_num};
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
      cnt_q  <= '0;
    end else begin
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end

  assign readdata = cnt_q[stat_addr];
`else
  logic unused_stat;
  assign unused_stat = ^stat_addr;
  assign readdata    = 32'd0;
`endif

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed bench for crossbar_scheduler: reset, single forward, contention
// with pointer rotation, parallel routing, backpressure, drops, async reset.
// Counter checks are active when STATS_EN is defined.
`timescale 1ns/1ps
module tb_crossbar_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty1, fifo_empty2, fifo_empty3;
  logic [31:0] fifo_out1, fifo_out2, fifo_out3;
  logic        out_full1, out_full2, out_full3;
  logic        fifo_rd1, fifo_rd2, fifo_rd3;
  logic [1:0]  mux_sel1, mux_sel2, mux_sel3;
  logic        out_ram_wr1, out_ram_wr2, out_ram_wr3;
  logic [1:0]  stat_addr;
  logic [31:0] readdata;
  int          checks = 0;
  int          errors = 0;

  crossbar_scheduler dut (
    .clk(clk), .reset(reset),
    .fifo_empty1(fifo_empty1), .fifo_empty2(fifo_empty2), .fifo_empty3(fifo_empty3),
    .fifo_out1(fifo_out1), .fifo_out2(fifo_out2), .fifo_out3(fifo_out3),
    .out_full1(out_full1), .out_full2(out_full2), .out_full3(out_full3),
    .fifo_rd1(fifo_rd1), .fifo_rd2(fifo_rd2), .fifo_rd3(fifo_rd3),
    .mux_sel1(mux_sel1), .mux_sel2(mux_sel2), .mux_sel3(mux_sel3),
    .out_ram_wr1(out_ram_wr1), .out_ram_wr2(out_ram_wr2), .out_ram_wr3(out_ram_wr3),
    .stat_addr(stat_addr), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Packed view of all strobes: {rd3..1, sel3, sel2, sel1, wr3..1}.
  function automatic logic [11:0] outs();
    return {fifo_rd3, fifo_rd2, fifo_rd1, mux_sel3, mux_sel2, mux_sel1,
            out_ram_wr3, out_ram_wr2, out_ram_wr1};
  endfunction

  function automatic logic [11:0] ex(input logic [2:0] rd, input logic [1:0] m1,
                                     input logic [1:0] m2, input logic [1:0] m3,
                                     input logic [2:0] wr);
    return {rd, m3, m2, m1, wr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the strobes just after the edge.
  task automatic cyc(input string tag, input logic [11:0] exp);
    @(posedge clk);
    #1;
    $display("step %-18s outs=%03h exp=%03h", tag, outs(), exp);
    chk(tag, {20'd0, outs()}, {20'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    fifo_empty1 = 1'b1; fifo_empty2 = 1'b1; fifo_empty3 = 1'b1;
    fifo_out1 = '0; fifo_out2 = '0; fifo_out3 = '0;
    out_full1 = 1'b0; out_full2 = 1'b0; out_full3 = 1'b0;
    stat_addr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {20'd0, outs()}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    reset = 1'b0;
    cyc("idle_arb", 12'h0);

    // Single forward: in1 -> out2
    fifo_out1 = 32'h800000AA; fifo_empty1 = 1'b0;
    cyc("single_xfer", ex(3'b001, 2'd0, 2'd1, 2'd0, 3'b010));
    fifo_empty1 = 1'b1;
    cyc("single_settle", 12'h0);
    cyc("single_arb", 12'h0);
`ifdef STATS_EN
    stat_addr = 2'd1; #1;
    chk("stat_fwd2_a", readdata, 32'd1);
`endif

    // Drop: in2 dest 0
    fifo_out2 = 32'h00001234; fifo_empty2 = 1'b0;
    cyc("drop_xfer", ex(3'b010, 2'd0, 2'd0, 2'd0, 3'b000));
    fifo_empty2 = 1'b1;
    cyc("drop_settle", 12'h0);
    cyc("drop_arb", 12'h0);
`ifdef STATS_EN
    stat_addr = 2'd3; #1;
    chk("stat_drop_a", readdata, 32'd1);
`endif

    // Contention on out3: in1 wins, then in3, then in1 again (pointer back at 1)
    fifo_out1 = 32'hC0000001; fifo_empty1 = 1'b0;
    fifo_out3 = 32'hC0000003; fifo_empty3 = 1'b0;
    cyc("cont_a", ex(3'b001, 2'd0, 2'd0, 2'd1, 3'b100));
    fifo_out1 = 32'hC0000011;
    cyc("cont_a_settle", 12'h0);
    cyc("cont_a_arb", 12'h0);
    cyc("cont_b", ex(3'b100, 2'd0, 2'd0, 2'd3, 3'b100));
    fifo_out3 = 32'hC0000013;
    cyc("cont_b_settle", 12'h0);
    cyc("cont_b_arb", 12'h0);
    cyc("cont_c", ex(3'b001, 2'd0, 2'd0, 2'd1, 3'b100));
    fifo_empty1 = 1'b1; fifo_empty3 = 1'b1;
    cyc("cont_c_settle", 12'h0);
    cyc("cont_c_arb", 12'h0);

    // Parallel: in1->out2, in2->out3, in3->out1
    fifo_out1 = 32'h80000011; fifo_out2 = 32'hC0000022; fifo_out3 = 32'h40000033;
    fifo_empty1 = 1'b0; fifo_empty2 = 1'b0; fifo_empty3 = 1'b0;
    cyc("parallel", ex(3'b111, 2'd3, 2'd1, 2'd2, 3'b111));
    fifo_empty1 = 1'b1; fifo_empty2 = 1'b1; fifo_empty3 = 1'b1;
    cyc("par_settle", 12'h0);
    cyc("par_arb", 12'h0);

    // Backpressure on out2 for 10 cycles, then release
    out_full2 = 1'b1;
    fifo_out1 = 32'h800000BB; fifo_empty1 = 1'b0;
    for (int i = 0; i < 10; i++) cyc("bp_hold", 12'h0);
    out_full2 = 1'b0;
    cyc("bp_release", ex(3'b001, 2'd0, 2'd1, 2'd0, 3'b010));
    fifo_empty1 = 1'b1;
    cyc("bp_settle", 12'h0);
    cyc("bp_arb", 12'h0);

    // Drop and forward in the same XFER
    fifo_out2 = 32'h00005678; fifo_empty2 = 1'b0;
    fifo_out1 = 32'hC00000CC; fifo_empty1 = 1'b0;
    cyc("drop_fwd", ex(3'b011, 2'd0, 2'd0, 2'd1, 3'b100));
    fifo_empty1 = 1'b1; fifo_empty2 = 1'b1;
    cyc("drop_fwd_settle", 12'h0);
    cyc("drop_fwd_arb", 12'h0);
`ifdef STATS_EN
    stat_addr = 2'd0; #1; chk("stat_fwd1", readdata, 32'd1);
    stat_addr = 2'd1; #1; chk("stat_fwd2", readdata, 32'd3);
    stat_addr = 2'd2; #1; chk("stat_fwd3", readdata, 32'd5);
    stat_addr = 2'd3; #1; chk("stat_drop", readdata, 32'd2);
`else
    stat_addr = 2'd2; #1; chk("readdata_zero", readdata, 32'd0);
`endif

    // Reset in the middle of an XFER (out2 pointer is 2 beforehand)
    fifo_out1 = 32'h800000EE; fifo_empty1 = 1'b0;
    cyc("rst_pre_xfer", ex(3'b001, 2'd0, 2'd1, 2'd0, 3'b010));
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outs", {20'd0, outs()}, 32'd0);
    stat_addr = 2'd1; #1;
    chk("rst_readdata", readdata, 32'd0);
    fifo_out3 = 32'h800000FF; fifo_empty3 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("rst_first_grant", ex(3'b001, 2'd0, 2'd1, 2'd0, 3'b010));
    fifo_empty1 = 1'b1;
    cyc("rst_settle", 12'h0);
    cyc("rst_arb", 12'h0);
    cyc("rst_second_grant", ex(3'b100, 2'd0, 2'd3, 2'd0, 3'b010));
    fifo_empty3 = 1'b1;
    cyc("rst_final_settle", 12'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crossbar_scheduler.md
# crossbar_scheduler

Round-robin scheduler that drains the three input FIFOs of the 3-port packet switch and routes each head word to its destination output. Each cycle-group it inspects every FIFO's show-ahead head word, resolves output contention, then pops the winning inputs. It drives the three output mux select lines and the output RAM write strobes. It sits between the Avalon-fed input FIFOs and the output buffer / packet display stage.

## Interface
- No parameters; FIFO width is fixed at 32, port count at 3.
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- fifo_empty1..3  in  1 each  input FIFO empty flags
- fifo_out1..3  in  32 each  show-ahead head word of each input FIFO; bits [31:30] = destination (1..3 = output port, 0 = drop)
- out_full1..3  in  1 each  output buffer K cannot accept a word
- fifo_rd1..3  out  1 each  pop strobe to input FIFO I
- mux_sel1..3  out  2 each  output K mux select: 0 = idle (zero source), 1..3 = input FIFO
- out_ram_wr1..3  out  1 each  write strobe into output buffer K
- stat_addr  in  2  statistics counter select
- readdata  out  32  selected statistics counter

## Operation
- FSM states: ARB, XFER, SETTLE. Reset state is ARB.
- **Eligibility:** in ARB, input I is eligible when fifo_emptyI=0 and either its destination is 0 or out_full[dest]=0.
- **Arbitration:** per output K, a 2-bit rotating pointer rr_ptrK (reset 1) names the highest-priority input; priority runs ptr, ptr+1, ptr+2, mod 3 over 1..3.
  - An input has one head word, so it competes for at most one output; no input is granted twice.
- **Drops:** dest-0 inputs are always granted in ARB as drops, with no contention.
- **ARB:** grants are computed combinationally and registered.
  - Any grant → XFER.
  - No grant → stay in ARB; all strobes stay 0.
- **XFER (one cycle):**
  - fifo_rdI=1 for every granted input, including drops.
  - mux_selK = granted input and out_ram_wrK=1 for every output with a forwarding grant.
  - Each granted output updates rr_ptrK to (granted input mod 3)+1.
- **SETTLE (one cycle):** all strobes 0 and mux_sel=0 while FIFO heads update; then → ARB.
- **Outside XFER:** mux_selK=0 and out_ram_wrK=0.
- **Width rules:** the 2-bit dest field is decoded directly; the pointer wraps 3→1.

## Timing
- All outputs are registered.
- **Reset values:** fifo_rd*=0, mux_sel*=0, out_ram_wr*=0, rr_ptr*=1, counters=0, readdata=0.
- **Latency:** head eligible in ARB cycle N → strobes asserted in cycle N+1 for exactly one cycle.
  - Next ARB evaluation is N+3.
  - Peak rate is one word per input per 3 cycles.
- **out_full:** sampled only in ARB. A change during XFER/SETTLE does not cancel an issued grant; the output buffer must reserve one slot before raising full.
- **fifo_empty:** sampled only in ARB. The FIFO may not go empty between ARB and XFER, because only this block pops it.
- **Simultaneous events:** three inputs to three distinct outputs are all granted in the same XFER. A drop and forwards can be granted in the same XFER.
- **Reset mid-operation:** asynchronously clears the strobes at once, with no partial pop. The FSM returns to ARB; pointers and counters are cleared.

## Configuration
- **STATS_EN defined:**
  - 32-bit counters fwd1..3 increment in XFER when out_ram_wrK=1; drop_cnt increments by the number of dropped words in that XFER (0..3).
  - All counters wrap modulo 2^32.
  - readdata = fwd1/fwd2/fwd3/drop_cnt for stat_addr 0/1/2/3, combinational from the registered counters.
- **STATS_EN undefined:** no counter registers; readdata is constant 0 and stat_addr is ignored.

## Test plan
- **Reset:** assert reset mid-XFER → all strobes 0 immediately; after release, the first grant uses rr_ptr=1 and readdata=0.
- **Single forward:** fifo_out1=0x800000AA (dest 2), empty1=0 in ARB cycle N → cycle N+1 shows fifo_rd1=1, mux_sel2=1, out_ram_wr2=1, for one cycle only.
- **Contention:** in1 and in3 both dest 3 (0xC0000001, 0xC0000003), rr_ptr3=1 → input 1 wins first XFER; input 3 wins the XFER 3 cycles later; rr_ptr3 ends at 1.
- **Parallel:** in1 dest 2, in2 dest 3, in3 dest 1 → a single XFER with mux_sel1=3, mux_sel2=1, mux_sel3=2, all fifo_rd=1, all out_ram_wr=1.
- **Backpressure:** out_full2=1 with in1 dest 2 for 10 cycles → no strobes; deassert in ARB cycle M → strobes at M+1.
- **Drop + stats (STATS_EN):** in2 head 0x00001234 (dest 0) → fifo_rd2 pulses with no out_ram_wr; stat_addr=3 reads 1; after the single-forward case, stat_addr=1 reads 1.
